// File: rtl/hack_pc_fetch_if.sv
// Fetch-side bundle between the Hack PC and the instruction ROM read stage.
// Handshake: the PC (master) drives addr/addr_valid and the ROM stage (slave)
// drives addr_ready. addr is transferred on a rising edge where addr_valid &&
// addr_ready. While addr_valid is high, addr is held until a transfer, a load
// or a Hack reset. addr_valid never depends on addr_ready.
interface hack_pc_fetch_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic             reset;
  logic [WIDTH-1:0] addr;
  logic             addr_valid;
  logic             addr_ready;
  logic             halted;

  modport master (
    input  in, load, inc, reset, addr_ready,
    output addr, addr_valid, halted
  );

  modport slave (
    output in, load, inc, reset, addr_ready,
    input  addr, addr_valid, halted
  );
endinterface

// File: rtl/hack_pc_fetch.sv
// Hack program counter with a ready/valid fetch port (reset > load > inc > hold).
// Optional ROM bound check with a latched HALT state: define HACK_PC_BOUND_CHECK_EN.
module hack_pc_fetch #(
  parameter int WIDTH     = 16,
  parameter int ROM_DEPTH = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  hack_pc_fetch_if.master   fetch,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1
`ifdef HACK_PC_BOUND_CHECK_EN
    , ST_HALT = 2'd2
`endif
  } state_e;

  if (ROM_DEPTH < 1 || ROM_DEPTH > (2 ** WIDTH)) begin : g_bad_rom_depth
    $error("hack_pc_fetch: ROM_DEPTH must lie in 1 .. 2**WIDTH");
  end

`ifdef HACK_PC_BOUND_CHECK_EN
  localparam logic [WIDTH:0] DEPTH_W = (WIDTH + 1)'(ROM_DEPTH);
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             boot_arm_q, boot_arm_d;

  // boot_arm_q marks that one edge has passed since reset release, so BOOT
  // spans one full cycle and the first fetch appears two edges after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      addr_q     <= '0;
      boot_arm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      boot_arm_q <= boot_arm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    boot_arm_d = 1'b1;
    case (state_q)
      ST_BOOT: begin
        if (boot_arm_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fetch.reset)                          addr_d = '0;
        else if (fetch.load)                      addr_d = fetch.in;
        else if (fetch.inc && fetch.addr_ready)   addr_d = addr_q + WIDTH'(1);
`ifdef HACK_PC_BOUND_CHECK_EN
        if (!fetch.reset && (fetch.load || (fetch.inc && fetch.addr_ready)) &&
            ({1'b0, addr_d} >= DEPTH_W))
          state_d = ST_HALT;
`endif
      end
`ifdef HACK_PC_BOUND_CHECK_EN
      ST_HALT: begin
        if (fetch.reset) begin
          addr_d  = '0;
          state_d = ST_RUN;
        end
      end
`endif
      default: state_d = ST_BOOT;
    endcase
  end

  // Outputs decode registered state only: no input-to-output path.
  always_comb begin
    fetch.addr_valid = (state_q == ST_RUN);
    fetch.halted     = 1'b0;
`ifdef HACK_PC_BOUND_CHECK_EN
    fetch.halted     = (state_q == ST_HALT);
`endif
  end

  assign fetch.addr = addr_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_hack_pc_fetch.sv
// Directed bench for hack_pc_fetch: transfers checked by a scoreboard monitor,
// state and reset behaviour checked at points in the stimulus sequence.
module tb_hack_pc_fetch;
  localparam int W = 16;
`ifdef HACK_PC_BOUND_CHECK_EN
  localparam int MAIN_DEPTH = 1024;
`else
  localparam int MAIN_DEPTH = 32768;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hack_pc_fetch_if #(.WIDTH(W)) bus ();
  logic [1:0] state_dbg;

  hack_pc_fetch #(.WIDTH(W), .ROM_DEPTH(MAIN_DEPTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch     (bus.master),
    .state_dbg (state_dbg)
  );

`ifdef HACK_PC_BOUND_CHECK_EN
  // Small-ROM instance sharing the same stimulus, for the bound fault.
  hack_pc_fetch_if #(.WIDTH(W)) bus8 ();
  logic [1:0] state_dbg8;
  assign bus8.in         = bus.in;
  assign bus8.load       = bus.load;
  assign bus8.inc        = bus.inc;
  assign bus8.reset      = bus.reset;
  assign bus8.addr_ready = bus.addr_ready;

  hack_pc_fetch #(.WIDTH(W), .ROM_DEPTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch     (bus8.master),
    .state_dbg (state_dbg8)
  );
`endif

  // scoreboard
  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.addr_valid === 1'b1 && bus.addr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL xfer_unexpected: got addr 0x%0h, expected no transfer", bus.addr);
      end else begin
        check("xfer_addr", 32'(bus.addr), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic ic, input logic rs,
                       input logic rdy, input logic [W-1:0] din);
    bus.load       = ld;
    bus.inc        = ic;
    bus.reset      = rs;
    bus.addr_ready = rdy;
    bus.in         = din;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
    #1 rst_n = 1'b0;
    #2;
    check("rst_addr",   32'(bus.addr),       32'h0);
    check("rst_valid",  32'(bus.addr_valid), 32'h0);
    check("rst_halted", 32'(bus.halted),     32'h0);
    tick();
    tick();
    check("rst_hold_valid", 32'(bus.addr_valid), 32'h0);

    // Reset release with ready=1, inc=1: one BOOT cycle then 0,1,2,3,4,5.
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(W'(i));
    tick();
    check("boot_valid", 32'(bus.addr_valid), 32'h0);
    check("boot_state", 32'(state_dbg),      32'h0);
    tick();
    check("run_valid", 32'(bus.addr_valid), 32'h1);
    check("run_addr0", 32'(bus.addr),       32'h0);
    repeat (5) tick();
    check("seq_addr5", 32'(bus.addr), 32'h5);

    // Backpressure: three stalled cycles hold addr 5.
    bus.addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_addr",  32'(bus.addr),       32'h5);
      check("bp_valid", 32'(bus.addr_valid), 32'h1);
    end
    bus.addr_ready = 1'b1;
    exp_q.push_back(W'(5));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("bp_release_addr", 32'(bus.addr), 32'h6);

    // Priority: load beats inc.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0009);
    tick();
    check("pri_setup_addr", 32'(bus.addr), 32'h9);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0123);
    exp_q.push_back(16'h0009);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("pri_load_addr", 32'(bus.addr), 32'h0123);

    // Priority: reset beats load and inc.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0009);
    tick();
    check("pri_setup2_addr", 32'(bus.addr), 32'h9);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0123);
    exp_q.push_back(16'h0009);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("pri_reset_addr", 32'(bus.addr), 32'h0);

    // inc without a transfer is dropped.
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    check("inc_no_xfer_addr", 32'(bus.addr), 32'h0);
    tick();
    check("inc_no_xfer_addr2", 32'(bus.addr), 32'h0);
    bus.inc = 1'b0;

    // Async reset between edges.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040);
    tick();
    bus.load = 1'b0;
    check("async_pre_addr", 32'(bus.addr), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("async_addr",  32'(bus.addr),       32'h0);
    check("async_valid", 32'(bus.addr_valid), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("async_boot_valid", 32'(bus.addr_valid), 32'h0);
    tick();
    check("async_run_valid", 32'(bus.addr_valid), 32'h1);
    check("async_run_addr",  32'(bus.addr),       32'h0);

`ifndef HACK_PC_BOUND_CHECK_EN
    // Wrap at 2^WIDTH.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    tick();
    bus.load = 1'b0;
    check("wrap_pre_addr", 32'(bus.addr), 32'hFFFF);
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
    exp_q.push_back(16'hFFFF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("wrap_addr",   32'(bus.addr),       32'h0);
    check("wrap_halted", 32'(bus.halted),     32'h0);
    check("wrap_valid",  32'(bus.addr_valid), 32'h1);
`else
    // Bound fault on the ROM_DEPTH=8 instance.
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0007);
    tick();
    bus.load = 1'b0;
    check("bound_pre_addr", 32'(bus8.addr), 32'h7);
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
    exp_q.push_back(16'h0007);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("bound_addr",        32'(bus8.addr),       32'h8);
    check("bound_halted",      32'(bus8.halted),     32'h1);
    check("bound_valid",       32'(bus8.addr_valid), 32'h0);
    check("bound_main_addr",   32'(bus.addr),        32'h8);
    check("bound_main_halted", 32'(bus.halted),      32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0003);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("halt_load_addr",   32'(bus8.addr),   32'h8);
    check("halt_load_halted", 32'(bus8.halted), 32'h1);
    bus.reset = 1'b1;
    tick();
    bus.reset = 1'b0;
    check("halt_reset_addr",   32'(bus8.addr),       32'h0);
    check("halt_reset_halted", 32'(bus8.halted),     32'h0);
    check("halt_reset_valid",  32'(bus8.addr_valid), 32'h1);
`endif

    tick();
    check("exp_q_drain", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
